barrido_display: RTL and testbench

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits. It takes a packed vector of N_DIGITOS 4-bit digit codes and scans them one at a time. Each scan slot starts with a programmable blanking interval so neighbouring digits do not ghost. The digit vector is snapshotted once per frame so a frame never mixes old and new values. It sits between the Booth multiplier result/BCD path and the board's anode/cathode pins, and generalises the single-digit cathode decoder to N digits with hex mode and scanning.

---
 rtl/barrido_display_if.sv | 14 +
 rtl/barrido_display.sv | 129 ++++++++++++
 tb/tb_barrido_display.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/barrido_display_if.sv
// Bundle between the digit source and the seven-segment scanner: digit codes in,
// active-low anode enables and cathode segments out.
interface barrido_display_if #(
  parameter int N_DIGITOS = 4
);
  // No handshake: digitos is a level, sampled by the scanner once per frame;
  // anodo/catodo_ON are registered levels that change on rising clock edges.
  logic [4*N_DIGITOS-1:0] digitos;
  logic [N_DIGITOS-1:0]   anodo;
  logic [6:0]             catodo_ON;

  modport master (output digitos, input anodo, input catodo_ON);
  modport slave  (input digitos, output anodo, output catodo_ON);
endinterface

// File: rtl/barrido_display.sv
// Time-multiplexed common-anode seven-segment scanner with per-slot blanking and
// frame-level snapshot of the digit codes. Optional macro: SUPRIMIR_CEROS_EN.
module barrido_display #(
  parameter int N_DIGITOS       = 4,
  parameter int CUENTA_REFRESCO = 100000,
  parameter int BLANK_CICLOS    = 1000,
  parameter int MODO_HEX        = 0
) (
  input  logic            clk,
  input  logic            rst,
  barrido_display_if.slave bus
);

  localparam int PRE_W = (CUENTA_REFRESCO > 1) ? $clog2(CUENTA_REFRESCO) : 1;
  localparam int IDX_W = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(CUENTA_REFRESCO - 1);
  localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CICLOS);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(N_DIGITOS - 1);

  logic [PRE_W-1:0]       r_pre;
  logic [IDX_W-1:0]       r_idx;
  logic [4*N_DIGITOS-1:0] r_snap;
  logic [N_DIGITOS-1:0]   r_anodo;
  logic [6:0]             r_catodo;

  logic                   w_pre_wrap;
  logic                   w_frame_start;
  logic                   w_activo;
  logic                   w_suprimido;
  logic [3:0]             w_nibble;
  logic [6:0]             w_seg;
  logic [N_DIGITOS-1:0]   w_anodo_nxt;
  logic [6:0]             w_catodo_nxt;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = (MODO_HEX != 0) ? 7'b0001000 : 7'b0000001;
      4'hB:    seg = (MODO_HEX != 0) ? 7'b1100000 : 7'b0000001;
      4'hC:    seg = (MODO_HEX != 0) ? 7'b0110001 : 7'b0000001;
      4'hD:    seg = (MODO_HEX != 0) ? 7'b1000010 : 7'b0000001;
      4'hE:    seg = (MODO_HEX != 0) ? 7'b0110000 : 7'b0000001;
      default: seg = (MODO_HEX != 0) ? 7'b0111000 : 7'b0000001;
    endcase
    return seg;
  endfunction

  assign w_pre_wrap    = (r_pre == PRE_MAX);
  assign w_frame_start = (r_pre == '0) && (r_idx == '0);
  assign w_activo      = (r_pre >= PRE_BLANK);

  always_comb begin
    w_nibble = 4'h0;
    for (int k = 0; k < N_DIGITOS; k++) begin
      if (IDX_W'(k) == r_idx) w_nibble = r_snap[4*k +: 4];
    end
  end

`ifdef SUPRIMIR_CEROS_EN
  logic [N_DIGITOS-1:0] w_ceros_arriba;

  // w_ceros_arriba[k] is set when nibble k and every more-significant nibble are 0.
  always_comb begin
    w_ceros_arriba = '0;
    w_ceros_arriba[N_DIGITOS-1] = (r_snap[4*(N_DIGITOS-1) +: 4] == 4'h0);
    for (int k = N_DIGITOS - 2; k >= 0; k--) begin
      w_ceros_arriba[k] = w_ceros_arriba[k+1] && (r_snap[4*k +: 4] == 4'h0);
    end
  end

  always_comb begin
    w_suprimido = 1'b0;
    for (int k = 1; k < N_DIGITOS; k++) begin
      if (IDX_W'(k) == r_idx) w_suprimido = w_ceros_arriba[k];
    end
  end
`else
  assign w_suprimido = 1'b0;
`endif

  assign w_seg = decode(w_nibble);

  always_comb begin
    w_anodo_nxt  = '1;
    w_catodo_nxt = 7'b1111111;
    if (w_activo && !w_suprimido) begin
      for (int k = 0; k < N_DIGITOS; k++) begin
        w_anodo_nxt[k] = !(IDX_W'(k) == r_idx);
      end
      w_catodo_nxt = w_seg;
    end
  end

  // Outputs are derived from the pre-edge counters, so the snapshot loaded at a
  // frame start is first displayed after the blanking interval of slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre    <= '0;
      r_idx    <= '0;
      r_snap   <= '0;
      r_anodo  <= '1;
      r_catodo <= 7'b1111111;
    end else begin
      if (w_pre_wrap) begin
        r_pre <= '0;
        r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      if (w_frame_start) r_snap <= bus.digitos;
      r_anodo  <= w_anodo_nxt;
      r_catodo <= w_catodo_nxt;
    end
  end

  assign bus.anodo     = r_anodo;
  assign bus.catodo_ON = r_catodo;

endmodule

// File: tb/tb_barrido_display.sv
// Bench for barrido_display: hex and decimal instances side by side, checked every
// cycle against a slot/frame arithmetic model plus hand-computed literal points.
module tb_barrido_display;

  localparam int N     = 4;
  localparam int R     = 8;
  localparam int B     = 2;
  localparam int FRAME = N * R;

  logic        clk;
  logic        rst;
  logic [15:0] digitos;

  int n_cmp  = 0;
  int n_fail = 0;
  int edge_n = 0;

  int          m_t    = 0;
  logic [15:0] m_snap = '0;
  logic [21:0] exp_q[$];

  barrido_display_if #(.N_DIGITOS(N)) bus_hex ();
  barrido_display_if #(.N_DIGITOS(N)) bus_dec ();

  assign bus_hex.digitos = digitos;
  assign bus_dec.digitos = digitos;

  barrido_display #(.N_DIGITOS(N), .CUENTA_REFRESCO(R), .BLANK_CICLOS(B), .MODO_HEX(1))
    dut_hex (.clk(clk), .rst(rst), .bus(bus_hex.slave));
  barrido_display #(.N_DIGITOS(N), .CUENTA_REFRESCO(R), .BLANK_CICLOS(B), .MODO_HEX(0))
    dut_dec (.clk(clk), .rst(rst), .bus(bus_dec.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) edge_n = 0;
    else     edge_n = edge_n + 1;
  end

  // model
  function automatic logic [6:0] seg(input logic [3:0] c, input bit hex);
    case (c)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return hex ? 7'b0001000 : 7'b0000001;
      4'hB: return hex ? 7'b1100000 : 7'b0000001;
      4'hC: return hex ? 7'b0110001 : 7'b0000001;
      4'hD: return hex ? 7'b1000010 : 7'b0000001;
      4'hE: return hex ? 7'b0110000 : 7'b0000001;
      default: return hex ? 7'b0111000 : 7'b0000001;
    endcase
  endfunction

  function automatic logic [10:0] modelo(input int t, input logic [15:0] snap, input bit hex);
    int         pos;
    int         k;
    bit         supp;
    logic [3:0] an;
    pos  = t % R;
    k    = (t / R) % N;
    supp = 1'b0;
`ifdef SUPRIMIR_CEROS_EN
    supp = (k > 0) && ((snap >> (4 * k)) == 16'h0);
`endif
    if (pos < B || supp) return {4'hF, 7'b1111111};
    an    = 4'hF;
    an[k] = 1'b0;
    return {an, seg(snap[4*k +: 4], hex)};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d: got anodo=%b catodo=%b, want anodo=%b catodo=%b",
               name, edge_n, act[10:7], act[6:0], exp[10:7], exp[6:0]);
    end
  endtask

  // scoreboard: expectation per edge, compared 1 time unit after that edge
  always @(posedge clk) begin : cmp_proc
    logic [21:0] e;
    if (rst) begin
      m_t    = 0;
      m_snap = '0;
      e      = {2{11'h7FF}};
    end else begin
      e = {modelo(m_t, m_snap, 1'b1), modelo(m_t, m_snap, 1'b0)};
      if (m_t % FRAME == 0) m_snap = digitos;
      m_t++;
    end
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    check("scan_hex", {bus_hex.anodo, bus_hex.catodo_ON}, e[21:11]);
    check("scan_dec", {bus_dec.anodo, bus_dec.catodo_ON}, e[10:0]);
  end

  // driver tasks
  task automatic lit(input string name, input logic [3:0] an,
                     input logic [6:0] cat_hex, input logic [6:0] cat_dec);
    check({name, "_hex"}, {bus_hex.anodo, bus_hex.catodo_ON}, {an, cat_hex});
    check({name, "_dec"}, {bus_dec.anodo, bus_dec.catodo_ON}, {an, cat_dec});
  endtask

  task automatic wait_edge(input int n);
    int i;
    i = 0;
    while (edge_n != n && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (edge_n != n) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_edge: got edge=%0d, want edge=%0d", edge_n, n);
    end
  endtask

  task automatic restart(input logic [15:0] v);
    digitos = v;
    rst     = 1'b1;
    @(negedge clk);
    lit("rst_pulse", 4'hF, 7'b1111111, 7'b1111111);
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    digitos = 16'h0000;
    @(negedge clk);
    lit("rst_first", 4'hF, 7'b1111111, 7'b1111111);
    digitos = 16'h1234;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // scan and snapshot: 1234, then 5678 applied before edge 12
    wait_edge(3);  lit("d0_start", 4'b1110, 7'b1001100, 7'b1001100);
    wait_edge(8);  lit("d0_end",   4'b1110, 7'b1001100, 7'b1001100);
    wait_edge(9);  lit("blank",    4'b1111, 7'b1111111, 7'b1111111);
    wait_edge(11); lit("d1_3",     4'b1101, 7'b0000110, 7'b0000110);
    digitos = 16'h5678;
    wait_edge(19); lit("d2_old",   4'b1011, 7'b0010010, 7'b0010010);
    wait_edge(27); lit("d3_old",   4'b0111, 7'b1001111, 7'b1001111);
    wait_edge(33); lit("snap_blk", 4'b1111, 7'b1111111, 7'b1111111);
    wait_edge(35); lit("d0_new",   4'b1110, 7'b0000000, 7'b0000000);
    wait_edge(43); lit("d1_new",   4'b1101, 7'b0001111, 7'b0001111);

    // hex decode after a mid-slot reset
    wait_edge(44);
    restart(16'h00AF);
    wait_edge(2);  lit("hex_blank", 4'b1111, 7'b1111111, 7'b1111111);
    wait_edge(3);  lit("hex_F",     4'b1110, 7'b0111000, 7'b0000001);
    wait_edge(11); lit("hex_A",     4'b1101, 7'b0001000, 7'b0000001);

    // reset at edge 20, then leading zeros 0050
    wait_edge(19);
    restart(16'h0050);
    wait_edge(3);  lit("z50_d0", 4'b1110, 7'b0000001, 7'b0000001);
    wait_edge(11); lit("z50_d1", 4'b1101, 7'b0100100, 7'b0100100);
`ifdef SUPRIMIR_CEROS_EN
    wait_edge(19); lit("z50_d2", 4'b1111, 7'b1111111, 7'b1111111);
    wait_edge(27); lit("z50_d3", 4'b1111, 7'b1111111, 7'b1111111);
`else
    wait_edge(19); lit("z50_d2", 4'b1011, 7'b0000001, 7'b0000001);
    wait_edge(27); lit("z50_d3", 4'b0111, 7'b0000001, 7'b0000001);
`endif

    // all-zero value
    wait_edge(40);
    restart(16'h0000);
    wait_edge(3);  lit("z00_d0", 4'b1110, 7'b0000001, 7'b0000001);
`ifdef SUPRIMIR_CEROS_EN
    wait_edge(11); lit("z00_d1", 4'b1111, 7'b1111111, 7'b1111111);
`else
    wait_edge(11); lit("z00_d1", 4'b1101, 7'b0000001, 7'b0000001);
`endif
    wait_edge(70);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
